// File: rtl/gray_code_counter.sv
`default_nettype none
// ============================================================================
// Module      : gray_code_counter
// Description : Registered up/down binary counter with coherent gray output,
//               wrap pulse and a sticky single-bit-change monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module gray_code_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray,
  output logic             tc,
  output logic             err
);

  localparam logic [WIDTH-1:0] c_all_ones = '1;
  localparam logic [WIDTH-1:0] c_zero     = '0;
  localparam logic [WIDTH-1:0] c_one      = WIDTH'(1);

  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic             r_tc;
  logic             r_err;

  logic [WIDTH-1:0] w_bin_next;
  logic [WIDTH-1:0] w_gray_next;
  logic [WIDTH-1:0] w_diff;
  logic             w_wrap;
  logic             w_step;
  logic             w_one_hot;

  always_comb begin
    w_bin_next = r_bin;
    w_wrap     = 1'b0;
    w_step     = 1'b0;
    if (load) begin
      w_bin_next = load_val;
    end else if (en) begin
      w_step = 1'b1;
      if (up_dn) begin
        w_bin_next = r_bin + c_one;
        w_wrap     = (r_bin == c_all_ones);
      end else begin
        w_bin_next = r_bin - c_one;
        w_wrap     = (r_bin == c_zero);
      end
    end
  end

  // Gray is built from the next binary value so both registers stay coherent.
  assign w_gray_next = w_bin_next ^ (w_bin_next >> 1);

  // r_gray holds the previous gray value; only counted steps are judged.
  assign w_diff    = r_gray ^ w_gray_next;
  assign w_one_hot = (w_diff != c_zero) && ((w_diff & (w_diff - c_one)) == c_zero);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bin  <= '0;
      r_gray <= '0;
      r_tc   <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_bin  <= w_bin_next;
      r_gray <= w_gray_next;
      r_tc   <= w_wrap;
      r_err  <= r_err | (w_step & ~w_one_hot);
    end
  end

  assign bin  = r_bin;
  assign gray = r_gray;
  assign tc   = r_tc;
  assign err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_gray_code_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_gray_code_counter
// Description : Scoreboard bench: driver queues expected responses, monitor
//               pops and compares one per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gray_code_counter;

  localparam int WIDTH = 4;

  typedef struct {
    logic [3:0] bin;
    logic [3:0] gray;
    logic       tc;
    logic       err;
    int         id;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       up_dn = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'h0;
  logic [3:0] bin;
  logic [3:0] gray;
  logic       tc;
  logic       err;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_id = 0;

  logic [3:0] gray_tab [16];
  logic [3:0] m_bin;
  logic       m_tc;

  gray_code_counter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .bin(bin), .gray(gray), .tc(tc), .err(err)
  );

  always #5 clk = ~clk;

  // Monitor: every clock presents a result; compare it with the oldest expectation.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (bin !== e.bin || gray !== e.gray || tc !== e.tc || err !== e.err ||
          gray !== (bin ^ (bin >> 1))) begin
        errors++;
        $display("FAIL step%0d: got bin=%h gray=%h tc=%b err=%b, expected bin=%h gray=%h tc=%b err=%b",
                 e.id, bin, gray, tc, err, e.bin, e.gray, e.tc, e.err);
      end
    end
  end

  task automatic drive(input logic r, input logic e, input logic u, input logic l,
                       input logic [3:0] lv, input logic [3:0] xb, input logic [3:0] xg,
                       input logic xt);
    exp_t x;
    @(negedge clk);
    rst_n = r; en = e; up_dn = u; load = l; load_val = lv;
    x.bin = xb; x.gray = xg; x.tc = xt; x.err = 1'b0; x.id = step_id;
    step_id++;
    exp_q.push_back(x);
  endtask

  initial begin
    gray_tab = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                 4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

    // Reset state
    drive(0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0);

    // Full up count with wrap back to zero
    for (int i = 0; i < 16; i++) begin
      logic [3:0] nb;
      nb = 4'(i + 1);
      drive(1, 1, 1, 0, 4'h0, nb, gray_tab[nb], (i == 15));
    end

    // Hold after wrap clears tc
    drive(1, 0, 1, 0, 4'h0, 4'h0, 4'h0, 0);

    // Down from reset wraps to all-ones
    drive(0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0);
    drive(1, 1, 0, 0, 4'h0, 4'hF, 4'h8, 1);
    drive(1, 1, 0, 0, 4'h0, 4'hE, 4'h9, 0);

    // Load beats en, then count on
    drive(1, 1, 1, 1, 4'hA, 4'hA, 4'hF, 0);
    drive(1, 1, 1, 0, 4'h0, 4'hB, 4'hE, 0);

    // Up/down around 7/8, then hold
    drive(1, 0, 0, 1, 4'h7, 4'h7, 4'h4, 0);
    drive(1, 1, 1, 0, 4'h0, 4'h8, 4'hC, 0);
    drive(1, 1, 0, 0, 4'h0, 4'h7, 4'h4, 0);
    for (int i = 0; i < 5; i++) drive(1, 0, 1, 0, 4'h0, 4'h7, 4'h4, 0);

    // Reset wins over load and en mid-count
    drive(1, 1, 1, 0, 4'h0, 4'h8, 4'hC, 0);
    drive(0, 1, 1, 1, 4'h5, 4'h0, 4'h0, 0);
    drive(1, 1, 1, 0, 4'h0, 4'h1, 4'h1, 0);
    drive(1, 1, 1, 0, 4'h0, 4'h2, 4'h3, 0);

    // Randomised traffic against a reference model
    drive(0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0);
    m_bin = 4'h0;
    for (int i = 0; i < 3000; i++) begin
      logic re, ru, rl;
      logic [3:0] rv;
      re = 1'($urandom_range(0, 3) != 0);
      ru = 1'($urandom_range(0, 1));
      rl = 1'($urandom_range(0, 15) == 0);
      rv = 4'($urandom_range(0, 15));
      m_tc = 1'b0;
      if (rl) m_bin = rv;
      else if (re) begin
        if (ru) begin m_tc = (m_bin == 4'hF); m_bin = m_bin + 4'h1; end
        else    begin m_tc = (m_bin == 4'h0); m_bin = m_bin - 4'h1; end
      end
      drive(1, re, ru, rl, rv, m_bin, m_bin ^ (m_bin >> 1), m_tc);
    end

    @(negedge clk);
    en = 1'b0; load = 1'b0;
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations never compared, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
